// File: rtl/tile_pkg.sv
// Shared constants, types and state encoding for the tile renderer control path.
package tile_pkg;

  localparam int TILE_WIDTH  = 32;
  localparam int TILE_HEIGHT = 32;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int MAP_COLS    = H_ACTIVE / TILE_WIDTH;
  localparam int MAP_ROWS    = V_ACTIVE / TILE_HEIGHT;
  localparam int MAP_DEPTH   = MAP_COLS * MAP_ROWS;
  localparam int ADDR_W      = $clog2(MAP_DEPTH);
  localparam int SPRITE_W    = 4;

  typedef logic [SPRITE_W-1:0] sprite_t;

  localparam sprite_t SPR_EMPTY = 4'd0;
  localparam sprite_t SPR_GRASS = 4'd1;
  localparam sprite_t SPR_WATER = 4'd2;
  localparam sprite_t SPR_TREE  = 4'd3;
  localparam sprite_t SPR_WALL  = 4'd4;

  // CLEAR: map wipe in progress; IDLE: game-logic writes may be granted.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } tile_state_e;

endpackage

// File: rtl/tile_map_ram.sv
// Single-port tile map storage: synchronous read, write-enable, contents not reset.
module tile_map_ram #(
  parameter int DEPTH = tile_pkg::MAP_DEPTH,
  parameter int AW    = tile_pkg::ADDR_W,
  parameter int DW    = tile_pkg::SPRITE_W
) (
  input  logic          i_Clk,
  input  logic          i_We,
  input  logic [AW-1:0] i_Addr,
  input  logic [DW-1:0] i_Wdata,
  output logic [DW-1:0] o_Rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write when enabled; read returns the pre-write contents of the addressed word.
  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      mem_q[i_Addr] <= i_Wdata;
    end
    rdata_q <= mem_q[i_Addr];
  end

  assign o_Rdata = rdata_q;

endmodule

// File: rtl/tile_render_ctrl.sv
// Per-pixel sprite lookup plus arbitration of the tile map port between the
// video path, the map clear engine and game-logic writes.
//
// Handshake (game-logic write): i_Wr_Req is a level held with stable
// i_Wr_Col/i_Wr_Row/i_Wr_Sprite until o_Wr_Ack pulses for one cycle; the
// request is taken only in IDLE during blanking, and ignored while the ack is
// being presented so a requester dropping i_Wr_Req on the ack cycle never
// produces a second commit. Out-of-range targets are acked without a write.
module tile_render_ctrl #(
  parameter int TILE_WIDTH  = tile_pkg::TILE_WIDTH,
  parameter int TILE_HEIGHT = tile_pkg::TILE_HEIGHT,
  parameter int H_ACTIVE    = tile_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = tile_pkg::V_ACTIVE,
  parameter int MAP_COLS    = tile_pkg::MAP_COLS,
  parameter int MAP_ROWS    = tile_pkg::MAP_ROWS
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic [9:0]                     i_Col,
  input  logic [9:0]                     i_Row,
  input  logic                           i_Active,
  input  logic                           i_Wr_Req,
  input  logic [4:0]                     i_Wr_Col,
  input  logic [3:0]                     i_Wr_Row,
  input  logic [3:0]                     i_Wr_Sprite,
  output logic                           o_Wr_Ack,
  input  logic                           i_Clear_Req,
  output logic                           o_Busy,
  output logic                           o_Valid,
  output logic [3:0]                     o_Sprite,
  output logic [$clog2(TILE_WIDTH)-1:0]  o_Local_X,
  output logic [$clog2(TILE_HEIGHT)-1:0] o_Local_Y,
  output tile_pkg::tile_state_e          o_Dbg_State
);

  import tile_pkg::*;

  localparam int TX_W  = $clog2(TILE_WIDTH);
  localparam int TY_W  = $clog2(TILE_HEIGHT);
  localparam int DEPTH = MAP_COLS * MAP_ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [9:0]    H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_LIM     = 10'(V_ACTIVE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Render front end
  logic             pix_visible;
  logic [9-TX_W:0]  tile_col;
  logic [9-TY_W:0]  tile_row;
  logic [AW-1:0]    render_addr;

  // Write decode
  logic             wr_in_range;
  logic [AW-1:0]    wr_addr;

  // Control state
  tile_state_e      state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  // RAM port
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  sprite_t          ram_wdata;
  sprite_t          ram_rdata;

  // Pipeline stages
  logic             v1_q;
  logic [TX_W-1:0]  lx1_q;
  logic [TY_W-1:0]  ly1_q;
  logic             valid_q;
  sprite_t          sprite_q, sprite_d;
  logic [TX_W-1:0]  lx_q;
  logic [TY_W-1:0]  ly_q;

  // Visibility test and tile index for the incoming pixel; invisible pixels read address 0.
  always_comb begin
    pix_visible = i_Active && (i_Col < H_LIM) && (i_Row < V_LIM);
    tile_col    = i_Col[9:TX_W];
    tile_row    = i_Row[9:TY_W];
    render_addr = '0;
    if (pix_visible) begin
      render_addr = AW'(tile_row) * AW'(MAP_COLS) + AW'(tile_col);
    end
  end

  // Map address of the game-logic write and whether it lands inside the map.
  always_comb begin
    wr_in_range = ({1'b0, i_Wr_Col} < 6'(MAP_COLS)) && ({1'b0, i_Wr_Row} < 5'(MAP_ROWS));
    wr_addr     = AW'(i_Wr_Row) * AW'(MAP_COLS) + AW'(i_Wr_Col);
  end

  // Port arbitration and next-state: render beats clear beats write; a clear request beats all.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ack_d      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = render_addr;
    ram_wdata  = SPR_EMPTY;
    if (i_Clear_Req) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end else if (!i_Active) begin
      case (state_q)
        ST_CLEAR: begin
          ram_addr  = clr_addr_q;
          ram_we    = 1'b1;
          ram_wdata = SPR_EMPTY;
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_Wr_Req && !ack_q) begin
            ack_d     = 1'b1;
            ram_addr  = wr_addr;
            ram_we    = wr_in_range;
            ram_wdata = i_Wr_Sprite;
          end
        end
        default: begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_CLEAR);
  end

  // Control FSM with registered ack and busy; reset launches a full clear from address 0.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  tile_map_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (SPRITE_W)
  ) u_map (
    .i_Clk   (i_Clk),
    .i_We    (ram_we && !i_Rst),
    .i_Addr  (ram_addr),
    .i_Wdata (ram_wdata),
    .o_Rdata (ram_rdata)
  );

  // Blank the sprite for pixels outside the visible area.
  always_comb begin
    sprite_d = v1_q ? ram_rdata : SPR_EMPTY;
  end

  // Two-stage render pipeline: stage 1 runs alongside the RAM read, stage 2 registers the outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      v1_q     <= 1'b0;
      lx1_q    <= '0;
      ly1_q    <= '0;
      valid_q  <= 1'b0;
      sprite_q <= SPR_EMPTY;
      lx_q     <= '0;
      ly_q     <= '0;
    end else begin
      v1_q     <= pix_visible;
      lx1_q    <= i_Col[TX_W-1:0];
      ly1_q    <= i_Row[TY_W-1:0];
      valid_q  <= v1_q;
      sprite_q <= sprite_d;
      lx_q     <= lx1_q;
      ly_q     <= ly1_q;
    end
  end

  assign o_Wr_Ack    = ack_q;
  assign o_Busy      = busy_q;
  assign o_Valid     = valid_q;
  assign o_Sprite    = sprite_q;
  assign o_Local_X   = lx_q;
  assign o_Local_Y   = ly_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_tile_render_ctrl.sv
// Directed bench for tile_render_ctrl: clear timing, render lookup, write arbitration, reset.
module tb_tile_render_ctrl;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_Rst;
  logic [9:0] i_Col;
  logic [9:0] i_Row;
  logic       i_Active;
  logic       i_Wr_Req;
  logic [4:0] i_Wr_Col;
  logic [3:0] i_Wr_Row;
  logic [3:0] i_Wr_Sprite;
  logic       o_Wr_Ack;
  logic       i_Clear_Req;
  logic       o_Busy;
  logic       o_Valid;
  logic [3:0] o_Sprite;
  logic [4:0] o_Local_X;
  logic [4:0] o_Local_Y;
  tile_pkg::tile_state_e o_Dbg_State;

  int checks   = 0;
  int failures = 0;

  tile_render_ctrl dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_Col       (i_Col),
    .i_Row       (i_Row),
    .i_Active    (i_Active),
    .i_Wr_Req    (i_Wr_Req),
    .i_Wr_Col    (i_Wr_Col),
    .i_Wr_Row    (i_Wr_Row),
    .i_Wr_Sprite (i_Wr_Sprite),
    .o_Wr_Ack    (o_Wr_Ack),
    .i_Clear_Req (i_Clear_Req),
    .o_Busy      (o_Busy),
    .o_Valid     (o_Valid),
    .o_Sprite    (o_Sprite),
    .o_Local_X   (o_Local_X),
    .o_Local_Y   (o_Local_Y),
    .o_Dbg_State (o_Dbg_State)
  );

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One active pixel followed by blanking; outputs are sampled two edges after the pixel.
  task automatic render(input int col, input int row);
    i_Col    = 10'(col);
    i_Row    = 10'(row);
    i_Active = 1'b1;
    tick();
    i_Active = 1'b0;
    i_Col    = '0;
    i_Row    = '0;
    tick();
  endtask

  // Raise a write request in blanking and wait (bounded) for the ack; returns cycles waited.
  task automatic do_write(input int c, input int r, input int s, output int n);
    i_Wr_Col    = 5'(c);
    i_Wr_Row    = 4'(r);
    i_Wr_Sprite = 4'(s);
    i_Wr_Req    = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_Wr_Ack && n < 400);
    i_Wr_Req = 1'b0;
  endtask

  // Count cycles o_Busy stays high starting at the current sample (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (o_Busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int bad;
    int acks;

    i_Rst = 1'b1; i_Col = '0; i_Row = '0; i_Active = 1'b0;
    i_Wr_Req = 1'b0; i_Wr_Col = '0; i_Wr_Row = '0; i_Wr_Sprite = '0;
    i_Clear_Req = 1'b0;

    // Reset values
    tick();
    chk("rst_busy",   o_Busy, 1);
    chk("rst_valid",  o_Valid, 0);
    chk("rst_sprite", o_Sprite, 0);
    chk("rst_ack",    o_Wr_Ack, 0);
    chk("rst_lx",     o_Local_X, 0);
    chk("rst_ly",     o_Local_Y, 0);
    chk("rst_state",  o_Dbg_State, tile_pkg::ST_CLEAR);

    // Reset-launched clear lasts exactly 300 blanking cycles
    i_Rst = 1'b0;
    count_busy(n);
    chk("clear_len", n, 300);
    chk("idle_state", o_Dbg_State, tile_pkg::ST_IDLE);

    // One pixel per tile: whole map reads sprite 0 and visible
    bad = 0;
    for (int tr = 0; tr < 15; tr++) begin
      for (int tc = 0; tc < 20; tc++) begin
        render(tc * 32 + tr, tr * 32 + tc);
        if (o_Valid !== 1'b1 || o_Sprite !== 4'd0) bad++;
      end
    end
    chk("scan_zero", bad, 0);

    // Blanking write, one-cycle ack, then lookup of pixel (100,70)
    do_write(3, 2, 4, n);
    chk("wr_ack_lat", n, 1);
    tick();
    chk("wr_ack_pulse", o_Wr_Ack, 0);
    render(100, 70);
    chk("px_valid",  o_Valid, 1);
    chk("px_sprite", o_Sprite, 4);
    chk("px_lx",     o_Local_X, 4);
    chk("px_ly",     o_Local_Y, 6);

    // Write held through 50 active cycles is not acked until blanking
    i_Col = 10'd0; i_Row = 10'd0; i_Active = 1'b1;
    i_Wr_Col = 5'd5; i_Wr_Row = 4'd1; i_Wr_Sprite = 4'd2; i_Wr_Req = 1'b1;
    acks = 0;
    repeat (50) begin
      tick();
      if (o_Wr_Ack) acks++;
    end
    chk("held_no_ack", acks, 0);
    i_Active = 1'b0;
    tick();
    chk("held_ack", o_Wr_Ack, 1);
    i_Wr_Req = 1'b0;
    tick();
    chk("held_ack_drop", o_Wr_Ack, 0);
    render(161, 34);
    chk("held_sprite", o_Sprite, 2);
    chk("held_lx", o_Local_X, 1);
    chk("held_ly", o_Local_Y, 2);

    // Boundary tile (19,14) and its last pixel
    do_write(19, 14, 1, n);
    chk("corner_ack", n, 1);
    tick();
    render(639, 479);
    chk("corner_valid",  o_Valid, 1);
    chk("corner_sprite", o_Sprite, 1);
    chk("corner_lx",     o_Local_X, 31);
    chk("corner_ly",     o_Local_Y, 31);

    // Pixels outside the visible area
    render(640, 10);
    chk("col640_valid",  o_Valid, 0);
    chk("col640_sprite", o_Sprite, 0);
    render(10, 480);
    chk("row480_valid",  o_Valid, 0);
    chk("row480_sprite", o_Sprite, 0);

    // Out-of-range writes are acked but leave the map alone
    do_write(20, 0, 3, n);
    chk("oor_col_ack", n, 1);
    tick();
    do_write(0, 15, 3, n);
    chk("oor_row_ack", n, 1);
    tick();
    render(0, 32);
    chk("oor_tile01", o_Sprite, 0);
    render(0, 0);
    chk("oor_tile00", o_Sprite, 0);

    // Clear request collides with a pending write: clear wins, write retried afterwards
    i_Wr_Col = 5'd7; i_Wr_Row = 4'd4; i_Wr_Sprite = 4'd3; i_Wr_Req = 1'b1;
    i_Clear_Req = 1'b1;
    tick();
    i_Clear_Req = 1'b0;
    chk("clr_busy", o_Busy, 1);
    chk("clr_no_ack", o_Wr_Ack, 0);
    n = 0;
    while (!o_Wr_Ack && n < 400) begin
      tick();
      n++;
    end
    chk("clr_wr_wait", n, 301);
    chk("clr_done", o_Busy, 0);
    i_Wr_Req = 1'b0;
    tick();
    render(100, 70);
    chk("clr_wiped_32", o_Sprite, 0);
    render(639, 479);
    chk("clr_wiped_corner", o_Sprite, 0);
    render(255, 159);
    chk("clr_retry_sprite", o_Sprite, 3);
    chk("clr_retry_lx", o_Local_X, 31);

    // Reset in the middle of a clear (address 150) with a pixel in flight
    i_Clear_Req = 1'b1;
    tick();
    i_Clear_Req = 1'b0;
    repeat (150) tick();
    i_Col = 10'd255; i_Row = 10'd159; i_Active = 1'b1;
    tick();
    i_Rst = 1'b1;
    tick();
    chk("mid_rst_busy",   o_Busy, 1);
    chk("mid_rst_valid",  o_Valid, 0);
    chk("mid_rst_sprite", o_Sprite, 0);
    chk("mid_rst_lx",     o_Local_X, 0);
    chk("mid_rst_ly",     o_Local_Y, 0);
    chk("mid_rst_ack",    o_Wr_Ack, 0);
    i_Rst = 1'b0; i_Active = 1'b0; i_Col = '0; i_Row = '0;
    count_busy(n);
    chk("mid_rst_clear_len", n, 300);
    render(255, 159);
    chk("mid_rst_wiped", o_Sprite, 0);

    // Active video pauses the clear without losing its place
    i_Clear_Req = 1'b1;
    tick();
    i_Clear_Req = 1'b0;
    repeat (100) tick();
    i_Col = 10'd0; i_Row = 10'd0; i_Active = 1'b1;
    repeat (40) tick();
    chk("pause_busy", o_Busy, 1);
    i_Active = 1'b0;
    count_busy(n);
    chk("pause_remaining", n, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
